// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing constants for the systolic array drain path.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_CAPTURE,
    ST_FLUSH
  } drain_state_e;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_COLS      = 5;
  localparam int DEFAULT_ROW_W     = DEFAULT_COLS * DEFAULT_WORD_SIZE;

  function automatic int row_width(input int cols, input int word_size);
    return cols * word_size;
  endfunction

endpackage

// File: rtl/systolic_drain_fifo.sv
// Aligned-row buffer: synchronous FIFO with push/pop in the same cycle even when full.
module systolic_drain_fifo #(
  parameter int WIDTH = 81,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;
  logic                        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/systolic_drain.sv
// Deskews the array's bottom outputs into whole rows and streams them out via a FIFO.
// Optional SYSTOLIC_DRAIN_RELU_EN clamps negative words to zero at FIFO write.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drain_start,
  input  logic [COLS*WORD_SIZE-1:0] bottom_in_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*WORD_SIZE-1:0] out_row_bus,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overflow
);

  localparam int ROW_W     = row_width(COLS, WORD_SIZE);
  localparam int CW        = $clog2((ROWS > COLS ? ROWS : COLS) + 1);
  localparam int FILL_LAST = (COLS > 2) ? COLS - 3 : 0;
  localparam int AW        = $clog2(FIFO_DEPTH);

  logic [COLS-1:0][WORD_SIZE-1:0] col_in, aligned, row_wr;
  drain_state_e                   state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           push, row_last, pop, overflow_q;
  logic                           fifo_full, fifo_empty;
  logic [AW:0]                    fifo_cnt;
  logic [ROW_W:0]                 fifo_rdata;

  assign col_in = bottom_in_bus;

  // Column c arrives c cycles late, so it gets COLS-1-c stages to line up with the last column.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_thru
      assign aligned[c] = col_in[c];
    end else begin : g_dly
      logic [D-1:0][WORD_SIZE-1:0] sr_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sr_q <= '0;
        end else begin
          sr_q[0] <= col_in[c];
          for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign aligned[c] = sr_q[D-1];
    end
`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign row_wr[c] = aligned[c][WORD_SIZE-1] ? '0 : aligned[c];
`else
    assign row_wr[c] = aligned[c];
`endif
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    row_last = 1'b0;
    unique case (state_q)
      ST_IDLE: if (drain_start) begin
        cnt_d   = '0;
        state_d = (COLS > 2) ? ST_FILL : ST_CAPTURE;
      end
      ST_FILL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FILL_LAST)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        push     = 1'b1;
        row_last = (cnt_q == CW'(ROWS - 1));
        cnt_d    = cnt_q + CW'(1);
        if (row_last) state_d = ST_FLUSH;
      end
      // Leave as the final row departs so busy drops right after that transfer.
      ST_FLUSH: if (fifo_empty || (fifo_cnt == (AW+1)'(1) && pop)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (push && fifo_full && !pop);
    end
  end

  systolic_drain_fifo #(
    .WIDTH(ROW_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i({row_last, row_wr}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  assign out_valid   = !fifo_empty;
  assign out_row_bus = fifo_rdata[ROW_W-1:0];
  assign out_last    = fifo_rdata[ROW_W];
  assign busy        = (state_q != ST_IDLE);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed and randomized drains of systolic_drain checked against a queue-based row model.
module tb_systolic_drain;

  localparam int ROWS = 5, COLS = 5, W = 16, DEPTH = 4, RW = COLS * W;

  typedef struct packed {
    logic [RW-1:0] row;
    logic          last;
  } ent_t;

  logic          clk = 1'b0, rst = 1'b0, drain_start = 1'b0, out_ready = 1'b0;
  logic [RW-1:0] bottom_in_bus = '0, out_row_bus;
  logic          out_valid, out_last, busy, overflow;

  always #5 clk = ~clk;

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .drain_start  (drain_start),
    .bottom_in_bus(bottom_in_bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row_bus  (out_row_bus),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow)
  );

  int            n_assert = 0, n_fail = 0, cyc = 0, t0 = 0;
  int            n_rows, n_last, first_v, busy_fall, bound;
  bit            drain_on = 0, busy_m = 0, ovf_m = 0, done_m = 0, busy_prev = 0;
  logic [W-1:0]  mat [ROWS][COLS];
  ent_t          q[$];
  logic [RW-1:0] got[$];
  logic [RW-1:0] tmp, exp_r;

  function automatic logic [W-1:0] relu(input logic [W-1:0] w);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    return w[W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_scn();
    n_rows = 0; n_last = 0; first_v = -1; busy_fall = -1;
    got.delete();
  endtask

  task automatic fill_inc();
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++) mat[k][c] = W'(16 * k + c);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++) mat[k][c] = W'($urandom);
  endtask

  // One clock cycle: drive skewed bus, check outputs against the model, advance the model.
  task automatic tick();
    bit            accept, pop;
    int            d, k;
    logic [RW-1:0] bus, er;
    ent_t          e;
    accept = rst && drain_start && !busy_m;
    if (accept) begin t0 = cyc; drain_on = 1; done_m = 0; end
    d = cyc - t0;
    for (int c = 0; c < COLS; c++)
      if (drain_on && d - c >= 0 && d - c < ROWS) bus[c*W +: W] = mat[d-c][c];
      else bus[c*W +: W] = W'($urandom);
    bottom_in_bus = bus;

    chk("valid", RW'(out_valid), RW'(q.size() != 0));
    if (q.size() != 0) begin
      chk("row", out_row_bus, q[0].row);
      chk("last", RW'(out_last), RW'(q[0].last));
    end
    chk("busy", RW'(busy), RW'(busy_m));
    chk("overflow", RW'(overflow), RW'(ovf_m));
    if (out_valid && first_v < 0) first_v = d;
    if (busy_prev && !busy) busy_fall = d;
    busy_prev = busy;
    if (out_valid && out_ready) begin
      got.push_back(out_row_bus);
      n_rows++;
      if (out_last) n_last++;
    end

    if (!rst) begin
      q.delete(); busy_m = 0; ovf_m = 0; drain_on = 0;
    end else begin
      pop = (q.size() != 0) && out_ready;
      k   = d - (COLS - 1);
      if (pop) void'(q.pop_front());
      if (drain_on && !done_m && k >= 0 && k < ROWS) begin
        if (q.size() == DEPTH && !pop) ovf_m = 1;
        else begin
          for (int c = 0; c < COLS; c++) er[c*W +: W] = relu(mat[k][c]);
          e.row  = er;
          e.last = (k == ROWS - 1);
          q.push_back(e);
        end
        if (k == ROWS - 1) done_m = 1;
      end
      if (accept) busy_m = 1;
      if (drain_on && done_m && q.size() == 0) begin busy_m = 0; drain_on = 0; end
    end
    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_valid", RW'(out_valid), '0);
    chk("rst_row", out_row_bus, '0);
    chk("rst_last", RW'(out_last), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_ovf", RW'(overflow), '0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Incrementing words, ready held high
    new_scn(); fill_inc(); out_ready = 1;
    drain_start = 1; tick(); drain_start = 0;
    repeat (14) tick();
    chk("s1_rows", RW'(n_rows), RW'(5));
    chk("s1_lastcnt", RW'(n_last), RW'(1));
    chk("s1_first_valid", RW'(first_v), RW'(5));
    chk("s1_busy_fall", RW'(busy_fall), RW'(10));
    for (int k = 0; k < ROWS; k++) begin
      for (int c = 0; c < COLS; c++) exp_r[c*W +: W] = W'(16 * k + c);
      tmp = (got.size() > k) ? got[k] : '0;
      chk("s1_row_data", tmp, exp_r);
    end

    // Negative word at (2,3)
    new_scn(); fill_inc(); mat[2][3] = 16'hFFF6;
    drain_start = 1; tick(); drain_start = 0;
    repeat (14) tick();
    tmp = (got.size() > 2) ? got[2] : '0;
`ifdef SYSTOLIC_DRAIN_RELU_EN
    chk("relu_w23", RW'(tmp[3*W +: W]), RW'(16'h0000));
`else
    chk("relu_w23", RW'(tmp[3*W +: W]), RW'(16'hFFF6));
`endif

    // Full FIFO with simultaneous pop
    new_scn(); fill_rand(); out_ready = 1;
    drain_start = 1; tick(); drain_start = 0;
    for (int i = 1; i < 16; i++) begin
      out_ready = !(i >= 4 && i <= 7);
      tick();
    end
    chk("s3_rows", RW'(n_rows), RW'(5));
    chk("s3_ovf", RW'(overflow), '0);

    // Second start while busy is ignored
    new_scn(); fill_rand(); out_ready = 1;
    drain_start = 1; tick(); drain_start = 0;
    tick(); tick();
    drain_start = 1; tick(); drain_start = 0;
    repeat (12) tick();
    chk("s4_rows", RW'(n_rows), RW'(5));
    chk("s4_lastcnt", RW'(n_last), RW'(1));

    // Backpressure until T+20: last row dropped
    new_scn(); fill_rand(); out_ready = 0;
    drain_start = 1; tick(); drain_start = 0;
    for (int i = 1; i < 32; i++) begin
      out_ready = (i >= 20);
      tick();
    end
    chk("s2_rows", RW'(n_rows), RW'(4));
    chk("s2_lastcnt", RW'(n_last), '0);
    chk("s2_ovf", RW'(overflow), RW'(1));

    // Asynchronous reset mid-capture
    new_scn(); fill_rand(); out_ready = 1;
    drain_start = 1; tick(); drain_start = 0;
    repeat (6) tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", RW'(out_valid), '0);
    chk("arst_row", out_row_bus, '0);
    chk("arst_last", RW'(out_last), '0);
    chk("arst_busy", RW'(busy), '0);
    chk("arst_ovf", RW'(overflow), '0);
    q.delete(); busy_m = 0; ovf_m = 0; drain_on = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    new_scn(); fill_rand();
    drain_start = 1; tick(); drain_start = 0;
    repeat (14) tick();
    chk("post_rst_rows", RW'(n_rows), RW'(5));

    // Random data, random ready, stray start pulses
    for (int r = 0; r < 6; r++) begin
      new_scn(); fill_rand();
      out_ready = 1'($urandom_range(0, 1));
      drain_start = 1; tick(); drain_start = 0;
      bound = 0;
      while ((busy_m || q.size() != 0) && bound < 200) begin
        out_ready   = 1'($urandom_range(0, 1));
        drain_start = ($urandom_range(0, 7) == 0);
        tick();
        bound++;
      end
      drain_start = 0;
      chk("rand_timeout", RW'(bound < 200), RW'(1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
